// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: bubble encoding, reset PC, FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fetch_stage_pkg;

    // addi x0,x0,0 -- the canonical RISC-V bubble
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch FSM encoding
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    // Word-align a redirect target by dropping the low two bits
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and an asynchronous imem.
// Latency: imem_dout is valid combinationally in the same cycle as imem_addr.
// Backpressure: none; the memory always answers.
//   master (fetch side): drives imem_addr, receives imem_dout
//   slave  (memory side): receives imem_addr, drives imem_dout
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout;

    modport master (output imem_addr, input  imem_dout);
    modport slave  (input  imem_addr, output imem_dout);
endinterface

// File: rtl/fetch_stage_pc_unit.sv
// Program counter register with next-PC mux (reset / redirect / hold / +4).
// Latency: new PC visible one cycle after the controlling inputs.
// Backpressure: hold freezes the PC; load (redirect) overrides hold.
//   clk, reset : clock, synchronous active-high reset
//   hold       : keep current PC
//   load       : take load_pc (word-aligned) as next PC
//   load_pc    : redirect target
//   pc         : current PC
module pc_unit
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] load_pc,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= align_pc(load_pc);
        end else if (!hold) begin
            // natural 32-bit wrap: FFFF_FFFC + 4 -> 0
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register, RUN/HALTED FSM, perf counters.
// Latency: instruction at PC appears on IF_ID_* one cycle after PC is presented.
// Backpressure: is_stall holds PC and IF/ID; redirect and halt insert a bubble.
//   clk, reset        : clock, synchronous active-high reset
//   is_stall          : hazard stall, hold PC and IF/ID
//   redirect_valid/pc : EX-resolved taken branch/jump
//   halt_req          : halting ecall seen in ID
//   imem              : instruction memory bus (master side)
//   IF_ID_*           : IF/ID pipeline register
//   is_halted         : fetch permanently stopped until reset
//   fetch_count       : cycles that wrote a valid instruction into IF/ID
//   stall_count       : cycles spent stalled
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          is_stall,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          halt_req,
    fetch_stage_if.master imem,
    output logic [31:0]   IF_ID_pc,
    output logic [31:0]   IF_ID_inst,
    output logic          IF_ID_valid,
    output logic          is_halted,
    output logic [31:0]   fetch_count,
    output logic [31:0]   stall_count
);

    logic [0:0]  state;
    logic [31:0] pc;
    logic        run;
    logic        do_redirect;
    logic        do_halt;
    logic        do_stall;
    logic        do_fetch;

    // Priority in RUN: redirect > halt > stall > normal. In HALTED all are off.
    assign run         = (state == ST_RUN);
    assign do_redirect = run && redirect_valid;
    assign do_halt     = run && !redirect_valid && halt_req;
    assign do_stall    = run && !redirect_valid && !halt_req && is_stall;
    assign do_fetch    = run && !redirect_valid && !halt_req && !is_stall;

    assign is_halted      = (state == ST_HALTED);
    assign imem.imem_addr = pc;

    pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk     (clk),
        .reset   (reset),
        .hold    (!do_fetch),
        .load    (do_redirect),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else if (do_halt) begin
            state <= ST_HALTED;
        end
    end

    // IF/ID: bubble on redirect/halt, load on fetch, otherwise hold
    // (which also keeps the bubble in place while HALTED).
    always_ff @(posedge clk) begin
        if (reset || do_redirect || do_halt) begin
            IF_ID_pc    <= 32'd0;
            IF_ID_inst  <= NOP_INST;
            IF_ID_valid <= 1'b0;
        end else if (do_fetch) begin
            IF_ID_pc    <= pc;
            IF_ID_inst  <= imem.imem_dout;
            IF_ID_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (do_fetch) fetch_count <= fetch_count + 32'd1;
            if (do_stall) stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a behavioural reference model.
// Latency: one model step per clock.
// Backpressure: n/a.
module tb_fetch_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] XMASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        is_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt_req = 1'b0;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        IF_ID_valid;
    logic        is_halted;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_halted;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_inst;
    logic        m_if_valid;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    fetch_stage_if imem ();
    assign imem.imem_dout = imem.imem_addr ^ XMASK;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .is_stall       (is_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .imem           (imem),
        .IF_ID_pc       (IF_ID_pc),
        .IF_ID_inst     (IF_ID_inst),
        .IF_ID_valid    (IF_ID_valid),
        .is_halted      (is_halted),
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},     imem.imem_addr,      m_pc);
        chk({tag, ".halted"}, {31'd0, is_halted},  {31'd0, m_halted});
        chk({tag, ".if_pc"},  IF_ID_pc,            m_if_pc);
        chk({tag, ".if_inst"},IF_ID_inst,          m_if_inst);
        chk({tag, ".if_vld"}, {31'd0, IF_ID_valid},{31'd0, m_if_valid});
        chk({tag, ".fcnt"},   fetch_count,         m_fetch);
        chk({tag, ".scnt"},   stall_count,         m_stall);
    endtask

    // Model: the behaviour of one clock edge expressed from the rules directly.
    task automatic model_step(input logic r, input logic st, input logic rv,
                              input logic [31:0] rp, input logic hr);
        if (r) begin
            m_pc = 32'd0; m_halted = 1'b0;
            m_if_pc = 32'd0; m_if_inst = NOP; m_if_valid = 1'b0;
            m_fetch = 32'd0; m_stall = 32'd0;
        end else if (m_halted) begin
            // frozen
        end else if (rv) begin
            m_pc = rp & ~32'd3;
            m_if_pc = 32'd0; m_if_inst = NOP; m_if_valid = 1'b0;
        end else if (hr) begin
            m_halted = 1'b1;
            m_if_pc = 32'd0; m_if_inst = NOP; m_if_valid = 1'b0;
        end else if (st) begin
            m_stall = m_stall + 1;
        end else begin
            m_if_pc = m_pc; m_if_inst = m_pc ^ XMASK; m_if_valid = 1'b1;
            m_pc = m_pc + 4;
            m_fetch = m_fetch + 1;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic cyc(input string tag, input logic r, input logic st, input logic rv,
                       input logic [31:0] rp, input logic hr);
        reset = r; is_stall = st; redirect_valid = rv; redirect_pc = rp; halt_req = hr;
        model_step(r, st, rv, rp, hr);
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    initial begin
        logic [31:0] fsave;
        logic [31:0] ssave;
        logic [31:0] rp;

        // reset state (asserted over a couple of edges, including from X)
        cyc("rst", 1, 0, 0, 0, 0);
        cyc("rst", 1, 1, 1, 32'h55, 1);
        chk("rst_addr", imem.imem_addr, 32'h0);

        // four free cycles: IF_ID_pc 0,4,8,C
        for (int i = 0; i < 4; i++) begin
            cyc("free", 0, 0, 0, 0, 0);
            chk("free_ifpc", IF_ID_pc, 32'(i * 4));
        end
        chk("free_fcnt", fetch_count, 32'd4);
        chk("free_pc", imem.imem_addr, 32'h10);

        // stall three cycles at PC 0x10
        for (int i = 0; i < 3; i++) cyc("stall", 0, 1, 0, 0, 0);
        chk("stall_pc", imem.imem_addr, 32'h10);
        chk("stall_ifpc", IF_ID_pc, 32'hC);
        chk("stall_cnt", stall_count, 32'd3);
        cyc("resume", 0, 0, 0, 0, 0);
        chk("resume_pc", imem.imem_addr, 32'h14);

        // redirect during stall
        cyc("redir", 0, 1, 1, 32'h103, 0);
        chk("redir_pc", imem.imem_addr, 32'h100);
        chk("redir_inst", IF_ID_inst, NOP);
        chk("redir_vld", {31'd0, IF_ID_valid}, 32'd0);

        // halt at PC 0x20, then ten cycles of noise
        cyc("to20", 0, 0, 1, 32'h20, 0);
        cyc("halt", 0, 0, 0, 0, 1);
        chk("halt_flag", {31'd0, is_halted}, 32'd1);
        fsave = fetch_count;
        ssave = stall_count;
        for (int i = 0; i < 10; i++)
            cyc("halted", 0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
        chk("halted_pc", imem.imem_addr, 32'h20);
        chk("halted_fcnt", fetch_count, fsave);
        chk("halted_scnt", stall_count, ssave);
        cyc("unhalt", 1, 0, 0, 0, 0);
        chk("unhalt_pc", imem.imem_addr, 32'h0);
        chk("unhalt_flag", {31'd0, is_halted}, 32'd0);

        // halt and redirect together: redirect wins
        cyc("hr_rv", 0, 0, 1, 32'h40, 1);
        chk("hr_rv_flag", {31'd0, is_halted}, 32'd0);
        chk("hr_rv_pc", imem.imem_addr, 32'h40);

        // PC wrap
        cyc("wrap_set", 0, 0, 1, 32'hFFFF_FFFF, 0);
        chk("wrap_set_pc", imem.imem_addr, 32'hFFFF_FFFC);
        cyc("wrap", 0, 0, 0, 0, 0);
        chk("wrap_pc", imem.imem_addr, 32'h0);
        chk("wrap_ifpc", IF_ID_pc, 32'hFFFF_FFFC);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rp = $urandom;
            cyc("rand",
                ($urandom_range(0, 149) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0),
                rp,
                ($urandom_range(0, 79) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
